mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access controller: MAR/MDR register pair plus a request/ack burst sequencer
// with per-beat timeout and a sticky error flag.
module mem_access_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned BURST_WIDTH = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mar_sclr,
  input  logic                   mar_en,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  input  logic                   mdr_en,
  input  logic                   mdr_alu_n,
  input  logic [DATA_WIDTH-1:0]  alu_in,
  input  logic                   wr_rdn,
  input  logic                   start,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_ack,
  output logic [ADDR_WIDTH-1:0]  MAR_m,
  output logic [DATA_WIDTH-1:0]  MDR_m,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  // Last REQ cycle index without ack before aborting.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StNext,
    StDone,
    StErr
  } state_e;

  state_e                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_mar, w_mar_nxt;
  logic [DATA_WIDTH-1:0]  r_mdr, w_mdr_nxt;
  logic [BURST_WIDTH-1:0] r_beat, w_beat_nxt;
  logic [BURST_WIDTH-1:0] r_len, w_len_nxt;
  logic                   r_wr, w_wr_nxt;
  logic [TmoW-1:0]        r_tmo, w_tmo_nxt;
  logic                   r_err, w_err_nxt;
  logic                   w_mem_req;
  logic                   w_busy;
  logic                   w_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mar_nxt   = r_mar;
    w_mdr_nxt   = r_mdr;
    w_beat_nxt  = r_beat;
    w_len_nxt   = r_len;
    w_wr_nxt    = r_wr;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    w_mem_req   = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
        if (mar_sclr) begin
          w_mar_nxt = '0;
        end else if (mar_en) begin
          w_mar_nxt = addr_in;
        end
        if (mdr_en) begin
          w_mdr_nxt = mdr_alu_n ? mem_rdata : alu_in;
        end
        if (start) begin
          w_wr_nxt    = wr_rdn;
          w_len_nxt   = burst_len;
          w_beat_nxt  = '0;
          w_tmo_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = StReq;
        end
      end

      StReq: begin
        w_mem_req = 1'b1;
        // An ack on the final allowed cycle still completes the beat.
        if (mem_ack) begin
          if (!r_wr) begin
            w_mdr_nxt = mem_rdata;
          end
          if (r_beat == r_len) begin
            w_state_nxt = StDone;
          end else begin
            w_beat_nxt  = r_beat + 1'b1;
            w_state_nxt = StNext;
          end
        end else if (r_tmo == TmoLast) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StErr;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      StNext: begin
        w_mar_nxt = r_mar + 1'b1;
        if (r_wr) begin
          w_mdr_nxt = alu_in;
        end
        w_tmo_nxt   = '0;
        w_state_nxt = StReq;
      end

      StDone: begin
        w_done      = 1'b1;
        w_state_nxt = StIdle;
      end

      StErr: begin
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mar  <= '0;
      r_mdr  <= '0;
      r_beat <= '0;
      r_len  <= '0;
      r_wr   <= 1'b0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_mar  <= w_mar_nxt;
      r_mdr  <= w_mdr_nxt;
      r_beat <= w_beat_nxt;
      r_len  <= w_len_nxt;
      r_wr   <= w_wr_nxt;
      r_tmo  <= w_tmo_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign mem_req   = w_mem_req;
  assign mem_we    = w_mem_req & r_wr;
  assign busy      = w_busy;
  assign done      = w_done;
  assign err       = r_err;
  assign mem_addr  = r_mar;
  assign MAR_m     = r_mar;
  assign mem_wdata = r_mdr;
  assign MDR_m     = r_mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-schedule reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized burst phase.
module tb_mem_access_ctrl;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mar_sclr = 1'b0, mar_en = 1'b0, mdr_en = 1'b0, mdr_alu_n = 1'b0;
  logic       wr_rdn = 1'b0, start = 1'b0, mem_ack = 1'b0;
  logic [7:0] addr_in = 8'h00, alu_in = 8'h00, mem_rdata = 8'h00;
  logic [1:0] burst_len = 2'd0;
  logic       mem_req, mem_we, busy, done, err;
  logic [7:0] mem_addr, mem_wdata, MAR_m, MDR_m;

  mem_access_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .BURST_WIDTH(2),
    .TIMEOUT    (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mar_sclr (mar_sclr),
    .mar_en   (mar_en),
    .addr_in  (addr_in),
    .mdr_en   (mdr_en),
    .mdr_alu_n(mdr_alu_n),
    .alu_in   (alu_in),
    .wr_rdn   (wr_rdn),
    .start    (start),
    .burst_len(burst_len),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .MAR_m    (MAR_m),
    .MDR_m    (MDR_m),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, req_cnt = 0, start_cyc = 0;
  int d0, r0, r;
  logic [7:0] obs_addr[$];
  logic [7:0] obs_wdata[$];
  logic       obs_we[$];

  // Model state: current and after-next-edge register contents.
  logic [7:0] m_mar = 8'h00, m_mdr = 8'h00, n_mar = 8'h00, n_mdr = 8'h00;
  logic       m_err = 1'b0, n_err = 1'b0;
  logic       exp_valid = 1'b0;
  logic       exp_req, exp_we, exp_busy, exp_done, exp_err;
  logic [7:0] exp_addr, exp_wdata;

  int         waits[4];
  logic [7:0] fix_rdata[4];
  logic [7:0] fix_alu[4];
  logic [7:0] seq_b[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (exp_valid) begin
      chk("mem_req", mem_req, exp_req);
      chk("mem_we", mem_we, exp_we);
      chk("mem_addr", mem_addr, exp_addr);
      chk("MAR_m", MAR_m, exp_addr);
      chk("mem_wdata", mem_wdata, exp_wdata);
      chk("MDR_m", MDR_m, exp_wdata);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("err", err, exp_err);
    end
    if (mem_req) req_cnt = req_cnt + 1;
    if (mem_req && mem_ack) begin
      obs_addr.push_back(mem_addr);
      obs_wdata.push_back(mem_wdata);
      obs_we.push_back(mem_we);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    m_mar = n_mar;
    m_mdr = n_mdr;
    m_err = n_err;
  endtask

  task automatic set_exp(input logic req, input logic we, input logic bsy, input logic dn);
    exp_req   = req;
    exp_we    = we & req;
    exp_busy  = bsy;
    exp_done  = dn;
    exp_err   = m_err;
    exp_addr  = m_mar;
    exp_wdata = m_mdr;
    exp_valid = 1'b1;
  endtask

  task automatic drive_quiet();
    start = 1'b0; mar_sclr = 1'b0; mar_en = 1'b0; mdr_en = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic drive_rand();
    start     = 1'b0;
    mar_sclr  = 1'(($urandom % 8) == 0);
    mar_en    = 1'(($urandom % 3) == 0);
    mdr_en    = 1'(($urandom % 3) == 0);
    mdr_alu_n = 1'($urandom);
    addr_in   = 8'($urandom);
    alu_in    = 8'($urandom);
    mem_rdata = 8'($urandom);
    mem_ack   = 1'($urandom);
    wr_rdn    = 1'($urandom);
    burst_len = 2'($urandom);
  endtask

  // Random control noise while busy; all of it must be ignored.
  task automatic drive_junk(input bit rnd);
    if (rnd) begin
      drive_rand();
      start = 1'($urandom);
    end else begin
      drive_quiet();
    end
  endtask

  task automatic idle_loads();
    n_mar = mar_sclr ? 8'h00 : (mar_en ? addr_in : m_mar);
    n_mdr = mdr_en ? (mdr_alu_n ? mem_rdata : alu_in) : m_mdr;
  endtask

  task automatic idle_cycle(input bit rnd);
    step();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    if (rnd) drive_rand();
    else drive_quiet();
    idle_loads();
  endtask

  task automatic run_txn(input bit wr, input logic [1:0] len, input bit ld_mar,
                         input logic [7:0] mar_v, input bit ld_mdr, input bit src,
                         input logic [7:0] mdr_v, input bit rnd);
    bit aborted = 1'b0;
    step();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    if (rnd) begin
      drive_rand();
    end else begin
      drive_quiet();
      mar_en    = ld_mar;
      addr_in   = mar_v;
      mdr_en    = ld_mdr;
      mdr_alu_n = src;
      if (src) mem_rdata = mdr_v;
      else alu_in = mdr_v;
    end
    start     = 1'b1;
    wr_rdn    = wr;
    burst_len = len;
    idle_loads();
    n_err     = 1'b0;
    start_cyc = cyc;
    for (int b = 0; b <= int'(len); b++) begin
      for (int k = 0; k < TMO; k++) begin
        step();
        set_exp(1'b1, wr, 1'b1, 1'b0);
        drive_junk(rnd);
        mem_ack = (k == waits[b]);
        if (!rnd) mem_rdata = fix_rdata[b];
        if (mem_ack) begin
          if (!wr) n_mdr = mem_rdata;
          break;
        end
        if (k == TMO - 1) begin
          n_err   = 1'b1;
          aborted = 1'b1;
        end
      end
      if (aborted) begin
        step();
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        drive_junk(rnd);
        return;
      end
      step();
      if (b == int'(len)) begin
        set_exp(1'b0, 1'b0, 1'b1, 1'b1);
        drive_junk(rnd);
      end else begin
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        drive_junk(rnd);
        if (!rnd) alu_in = fix_alu[b];
        n_mar = m_mar + 8'd1;
        if (wr) n_mdr = alu_in;
      end
    end
  endtask

  initial begin
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_MAR", MAR_m, 0);
    chk("rst_MDR", MDR_m, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycle(0);
    idle_cycle(0);

    // Single read with MAR load in the start cycle.
    waits[0] = 0; fix_rdata[0] = 8'hA5;
    d0 = done_cnt;
    run_txn(1'b0, 2'd0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycle(0);
    chk("single_MDR", MDR_m, 8'hA5);
    chk("single_MAR", MAR_m, 8'h10);
    chk("single_done_pulses", done_cnt - d0, 1);

    // 4-beat read wrapping past 0xFF; done on the ninth cycle counting the start cycle.
    for (int i = 0; i < 4; i++) begin
      waits[i] = 0;
      fix_rdata[i] = 8'(8'h11 * (i + 1));
    end
    obs_addr.delete();
    run_txn(1'b0, 2'd3, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycle(0);
    chk("burst_beats", obs_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_addr.size()) chk("burst_addr", obs_addr[i], seq_b[i]);
    end
    chk("burst_latency", done_cyc - start_cyc, 8);
    chk("burst_MDR", MDR_m, 8'h44);

    // 2-beat write: MDR from alu in the start cycle, next beat from alu during NEXT.
    waits[0] = 0; waits[1] = 0; fix_alu[0] = 8'h7E;
    obs_wdata.delete(); obs_we.delete();
    run_txn(1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0);
    idle_cycle(0);
    chk("wr_beats", obs_wdata.size(), 2);
    if (obs_wdata.size() == 2) begin
      chk("wr_data0", obs_wdata[0], 8'h3C);
      chk("wr_data1", obs_wdata[1], 8'h7E);
      chk("wr_we0", obs_we[0], 1);
      chk("wr_we1", obs_we[1], 1);
    end

    // Timeout with no ack at all.
    waits[0] = TMO; d0 = done_cnt; r0 = req_cnt;
    run_txn(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycle(0);
    chk("tmo_err", err, 1);
    chk("tmo_req_cycles", req_cnt - r0, TMO);
    chk("tmo_no_done", done_cnt - d0, 0);
    repeat (3) idle_cycle(0);
    chk("tmo_err_sticky", err, 1);
    waits[0] = 1; fix_rdata[0] = 8'h5A;
    run_txn(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("err_cleared", err, 0);
    idle_cycle(0);

    // Ack arriving on the timeout cycle completes the beat.
    waits[0] = TMO - 1; fix_rdata[0] = 8'hC3; d0 = done_cnt; r0 = req_cnt;
    run_txn(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycle(0);
    chk("late_ack_done", done_cnt - d0, 1);
    chk("late_ack_err", err, 0);
    chk("late_ack_MDR", MDR_m, 8'hC3);
    chk("late_ack_req_cycles", req_cnt - r0, TMO);

    // Clear and load together: clear wins.
    step();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    drive_quiet();
    mar_sclr = 1'b1; mar_en = 1'b1; addr_in = 8'h55;
    idle_loads();
    idle_cycle(0);
    chk("sclr_priority", MAR_m, 8'h00);

    // Reset pulse in the second beat of a write burst.
    step();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    drive_quiet();
    mar_en = 1'b1; addr_in = 8'h40; mdr_en = 1'b1; mdr_alu_n = 1'b0; alu_in = 8'h21;
    start = 1'b1; wr_rdn = 1'b1; burst_len = 2'd1;
    idle_loads();
    n_err = 1'b0;
    step();
    set_exp(1'b1, 1'b1, 1'b1, 1'b0);
    drive_quiet();
    mem_ack = 1'b1;
    step();
    set_exp(1'b0, 1'b0, 1'b1, 1'b0);
    drive_quiet();
    alu_in = 8'h99;
    n_mar = m_mar + 8'd1;
    n_mdr = alu_in;
    step();
    set_exp(1'b1, 1'b1, 1'b1, 1'b0);
    drive_quiet();
    #2;
    exp_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_MAR", MAR_m, 0);
    chk("arst_MDR", MDR_m, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    n_mar = 8'h00; n_mdr = 8'h00; n_err = 1'b0;
    step();
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    drive_quiet();
    idle_loads();
    repeat (3) idle_cycle(0);

    // Randomized bursts with noise on every ignored input.
    repeat (150) begin
      repeat ($urandom % 3) idle_cycle(1);
      for (int b = 0; b < 4; b++) begin
        r = int'($urandom % 16);
        if (r < 9) waits[b] = int'($urandom % 2);
        else if (r < 13) waits[b] = int'($urandom % 6);
        else if (r == 13) waits[b] = TMO - 1;
        else if (r == 14) waits[b] = TMO;
        else waits[b] = 0;
      end
      run_txn(1'($urandom), 2'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    repeat (3) idle_cycle(1);
    exp_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
